mfdfa_chunk_sched: RTL and testbench
====================================

Name: mfdfa_chunk_sched

Overview:
Parametrised chunk scheduler for the MFDFA engine, generalising the fixed 3-scale chunking step.
- Takes a series length and N_CH per-scale chunk counts.
- Computes chunk sizes with one shared sequential divider.
- Streams (start index, end index, chunk id) descriptors per scale over valid/ready to downstream queue/iter units.
- Accumulates the per-chunk fluctuation results those units return, and flags completion.

Parameters:
N_CH, 3, number of scales (channels)
W, 32, width of lengths, counts, indices and result words
ACC_W, 64, per-channel accumulator width (must be >= W)

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
n_samples  in  W  series length
n_chunks  in  N_CH*W  chunk count per channel; channel c uses bits [c*W +: W]
busy  out  1  high from accepted start until DONE exits
done  out  1  one-cycle pulse at completion or error
err  out  1  sticky config error; cleared by the next accepted start
desc_valid  out  N_CH  descriptor valid per channel
desc_ready  in  N_CH  downstream ready per channel
desc_si  out  N_CH*W  chunk start index
desc_ei  out  N_CH*W  chunk end index (inclusive)
desc_id  out  N_CH*W  chunk ordinal k
chunk_size  out  N_CH*W  computed size per channel; valid once DIV completes
res_valid  in  N_CH  result strobe per channel
res_data  in  N_CH*W  unsigned result word
res_sum  out  N_CH*ACC_W  per-channel sum of accepted results
res_cnt  out  N_CH*W  per-channel count of accepted results
res_ovf  out  1  sticky; a result arrived on a channel whose count already equals its n_chunks

Behaviour:
- Reset (async, Rst low): state=IDLE.
  - All outputs 0: busy, done, err, desc_valid, all payloads, chunk_size, res_sum, res_cnt, res_ovf.
  - Reset mid-operation aborts immediately. No descriptor is completed after Rst deasserts.
- States: IDLE -> CHECK -> DIV -> DISPATCH -> DONE -> IDLE.
- IDLE: on start=1, capture n_samples and n_chunks; clear err, res_ovf, res_sum, res_cnt; set busy; go to CHECK.
- start outside IDLE is ignored.
- CHECK (1 cycle): if any n_chunks[c]==0 or n_chunks[c]>n_samples, set err=1 and go to DONE. No descriptors are issued. Otherwise go to DIV.
- DIV: restoring divider, exactly W cycles per channel, channels in order 0..N_CH-1, total N_CH*W cycles.
  - chunk_size[c] = floor(n_samples / n_chunks[c]).
  - The remainder tail samples are never covered.
- DISPATCH: channels run independently and concurrently.
  - Per-channel counter k starts at 0.
  - desc_si = k*size, desc_ei = k*size+size-1, desc_id = k.
  - desc_valid[c] rises on the first DISPATCH cycle.
  - Transfer occurs when valid&ready; k increments on the same edge.
  - While valid&!ready, payload must stay stable.
  - After transfer of k = n_chunks[c]-1, valid[c] drops.
  - Back-to-back transfers at 1 per cycle per channel are required.
- Results: res_valid[c] is accepted in DISPATCH only.
  - If res_cnt[c] < n_chunks[c]: res_sum[c] += zero-extended res_data[c] and res_cnt[c]++.
  - Otherwise set res_ovf and discard the word.
  - Results may arrive in the same cycle as descriptor transfers, and on all channels at once.
  - Results are ignored in every other state.
- DISPATCH -> DONE when every channel has issued all descriptors and res_cnt[c]==n_chunks[c] for all c. This is evaluated on registered state, so the transition occurs the cycle after the last event.
- DONE (1 cycle): done=1, busy=0 on entry to IDLE.
- res_sum, res_cnt, chunk_size and err hold until the next accepted start.
- Accumulators wrap modulo 2^ACC_W; no saturation.

Test Plan:
- Functional chunking:
  - Stimulus: n_samples=301, n_chunks={10,20,30}, all ready=1.
  - Required: chunk_size={30,15,10}; first valid exactly 1+3*32 cycles after the cycle following start.
  - Ch0 descriptors (0,29,0)..(270,299,9); ch1 last (285,299,19); ch2 last (290,299,29).
  - No descriptor references index 300.
- Backpressure:
  - Stimulus: same config, desc_ready[1] toggled 0/1 pseudo-randomly.
  - Required: ch1 payload stable while stalled; exactly 20 ch1 transfers in order with ids 0..19; ch0/ch2 unaffected.
- Result accumulation:
  - Stimulus: return res_data=k+1 once per ch2 descriptor; return 1 on ch0 and ch1.
  - Required: res_sum={10,20,465}, res_cnt={10,20,30}; done pulses exactly one cycle; busy falls.
  - Overflow: a 31st ch2 result sets res_ovf=1 and leaves the sum at 465.
- Config errors:
  - Stimulus: n_chunks[1]=0.
  - Required: err=1; done pulses 2 cycles after start; desc_valid never rises.
  - Stimulus: repeat with n_chunks[0]=302, n_samples=301.
  - Required: same response.
  - Stimulus: n_chunks=301.
  - Required: size=1 and 301 descriptors.
- Reset and start robustness:
  - Stimulus: assert Rst low mid-DISPATCH.
  - Required: all outputs 0 asynchronously and state IDLE; a fresh start reproduces the functional-chunking results.
  - Stimulus: start pulse during DIV.
  - Required: ignored; no state change.

Source files
------------

// File: rtl/mfdfa_chunk_sched.sv
`default_nettype none
// mfdfa_chunk_sched: sizes N_CH chunkings of one series with a shared restoring divider,
// streams per-channel chunk descriptors and accumulates the returned per-chunk results.
module mfdfa_chunk_sched #(
   parameter int N_CH  = 3,
   parameter int W     = 32,
   parameter int ACC_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W-1:0]          n_samples,
   input  logic [N_CH*W-1:0]     n_chunks,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [N_CH-1:0]       desc_valid,
   input  logic [N_CH-1:0]       desc_ready,
   output logic [N_CH*W-1:0]     desc_si,
   output logic [N_CH*W-1:0]     desc_ei,
   output logic [N_CH*W-1:0]     desc_id,
   output logic [N_CH*W-1:0]     chunk_size,
   input  logic [N_CH-1:0]       res_valid,
   input  logic [N_CH*W-1:0]     res_data,
   output logic [N_CH*ACC_W-1:0] res_sum,
   output logic [N_CH*W-1:0]     res_cnt,
   output logic                  res_ovf
);
   localparam int CW  = (W > 1) ? $clog2(W) : 1;
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_DIV      = 3'd2,
      S_DISPATCH = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [W-1:0]    ns_q;
   logic [W-1:0]    nch_q [N_CH];
   logic            err_q, ovf_q;
   logic [CW-1:0]   div_cnt;
   logic [CHW-1:0]  div_ch;
   logic [W-1:0]    quo_q, rem_q;

   logic [W:0]      rem_sh, div_ext;
   logic            div_ge, div_step_last, div_last;
   logic [W-1:0]    quo_nx, rem_nx;
   logic            cfg_bad, all_done;
   logic [N_CH-1:0] issued_vec, ovf_hit;

   // One restoring-division step per cycle on the channel currently selected by div_ch.
   always_comb begin
      div_ext       = {1'b0, nch_q[div_ch]};
      rem_sh        = {rem_q, quo_q[W-1]};
      div_ge        = (rem_sh >= div_ext);
      rem_nx        = div_ge ? W'(rem_sh - div_ext) : rem_sh[W-1:0];
      quo_nx        = {quo_q[W-2:0], div_ge};
      div_step_last = (div_cnt == CW'(W-1));
      div_last      = div_step_last && (div_ch == CHW'(N_CH-1));
   end

   always_comb begin
      cfg_bad  = 1'b0;
      all_done = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if ((nch_q[c] == '0) || (nch_q[c] > ns_q))
            cfg_bad = 1'b1;
         if (!issued_vec[c] || (res_cnt[c*W +: W] != nch_q[c]))
            all_done = 1'b0;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:     if (start) state_nx = S_CHECK;
         S_CHECK:    state_nx = cfg_bad ? S_DONE : S_DIV;
         S_DIV:      if (div_last) state_nx = S_DISPATCH;
         S_DISPATCH: if (all_done) state_nx = S_DONE;
         S_DONE:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ns_q    <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         div_cnt <= '0;
         div_ch  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         for (int c = 0; c < N_CH; c++) nch_q[c] <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               ns_q  <= n_samples;
               err_q <= 1'b0;
               ovf_q <= 1'b0;
               for (int c = 0; c < N_CH; c++) nch_q[c] <= n_chunks[c*W +: W];
            end
            S_CHECK: begin
               if (cfg_bad) err_q <= 1'b1;
               div_cnt <= '0;
               div_ch  <= '0;
               quo_q   <= ns_q;
               rem_q   <= '0;
            end
            S_DIV: begin
               if (div_step_last) begin
                  div_cnt <= '0;
                  div_ch  <= div_ch + CHW'(1);
                  quo_q   <= ns_q;
                  rem_q   <= '0;
               end else begin
                  div_cnt <= div_cnt + CW'(1);
                  quo_q   <= quo_nx;
                  rem_q   <= rem_nx;
               end
            end
            S_DISPATCH: if (|ovf_hit) ovf_q <= 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic [W-1:0]     size, si, ei, id, cnt;
      logic [ACC_W-1:0] sum;
      logic             issued, xfer, res_ok;

      assign xfer          = desc_valid[c] & desc_ready[c];
      assign res_ok        = (cnt < nch_q[c]);
      assign ovf_hit[c]    = (state == S_DISPATCH) && res_valid[c] && !res_ok;
      assign issued_vec[c] = issued;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            size   <= '0;
            si     <= '0;
            ei     <= '0;
            id     <= '0;
            cnt    <= '0;
            sum    <= '0;
            issued <= 1'b0;
         end else if ((state == S_IDLE) && start) begin
            size   <= '0;
            cnt    <= '0;
            sum    <= '0;
            issued <= 1'b0;
         end else if ((state == S_DIV) && div_step_last && (div_ch == CHW'(c))) begin
            size <= quo_nx;
            si   <= '0;
            ei   <= quo_nx - W'(1);
            id   <= '0;
         end else if (state == S_DISPATCH) begin
            // Payload only advances on a handshake, so it stays put while stalled.
            if (xfer) begin
               si <= si + size;
               ei <= ei + size;
               id <= id + W'(1);
               if (id == nch_q[c] - W'(1)) issued <= 1'b1;
            end
            if (res_valid[c] && res_ok) begin
               sum <= sum + ACC_W'(res_data[c*W +: W]);
               cnt <= cnt + W'(1);
            end
         end
      end

      assign desc_valid[c]             = (state == S_DISPATCH) && !issued;
      assign desc_si[c*W +: W]         = si;
      assign desc_ei[c*W +: W]         = ei;
      assign desc_id[c*W +: W]         = id;
      assign chunk_size[c*W +: W]      = size;
      assign res_sum[c*ACC_W +: ACC_W] = sum;
      assign res_cnt[c*W +: W]         = cnt;
   end

   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);
   assign err     = err_q;
   assign res_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mfdfa_chunk_sched.sv
`default_nettype none
// Bench for mfdfa_chunk_sched: table-driven configurations with a descriptor scoreboard,
// plus hand-written overflow and mid-dispatch reset sequences.
module tb_mfdfa_chunk_sched;
   localparam int NC = 3;
   localparam int DW = 32;
   localparam int AW = 64;
   localparam int FIRST_LAT = 1 + NC*DW;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [DW-1:0]    n_samples;
   logic [NC*DW-1:0] n_chunks;
   logic             busy, done, err, res_ovf;
   logic [NC-1:0]    desc_valid, desc_ready, res_valid;
   logic [NC*DW-1:0] desc_si, desc_ei, desc_id, chunk_size, res_data, res_cnt;
   logic [NC*AW-1:0] res_sum;

   mfdfa_chunk_sched #(.N_CH(NC), .W(DW), .ACC_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .n_chunks(n_chunks),
      .busy(busy), .done(done), .err(err), .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_si(desc_si), .desc_ei(desc_ei), .desc_id(desc_id), .chunk_size(chunk_size),
      .res_valid(res_valid), .res_data(res_data), .res_sum(res_sum), .res_cnt(res_cnt),
      .res_ovf(res_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] si, ei, id;
   } desc_t;

   typedef struct {
      int unsigned ns, n0, n1, n2;
      bit          exp_err, rnd, glitch;
   } cfg_t;

   int          checks = 0;
   int          failures = 0;
   desc_t       exp_q [NC][$];
   int unsigned pend_q [NC][$];
   bit          stalled [NC];
   logic [95:0] prev_pl [NC];
   cfg_t        tbl [6];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int c = 0; c < NC; c++) begin
         exp_q[c].delete();
         pend_q[c].delete();
         stalled[c] = 1'b0;
      end
   endtask

   task automatic push_expected(input int unsigned ns, input int unsigned n0,
                                input int unsigned n1, input int unsigned n2);
      int unsigned n [NC];
      desc_t d;
      n[0] = n0; n[1] = n1; n[2] = n2;
      for (int c = 0; c < NC; c++) begin
         int unsigned sz = ns / n[c];
         for (int unsigned k = 0; k < n[c]; k++) begin
            d.si = k*sz;
            d.ei = k*sz + sz - 1;
            d.id = k;
            exp_q[c].push_back(d);
         end
      end
   endtask

   task automatic do_start(input int unsigned ns, input int unsigned n0,
                           input int unsigned n1, input int unsigned n2);
      n_samples = ns;
      n_chunks  = {n2, n1, n0};
      start     = 1'b1;
      cycle();
      start     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_valid"}, desc_valid, 0);
      check({tag, "_payload"}, desc_si | desc_ei | desc_id, 0);
      check({tag, "_size"}, chunk_size, 0);
      check({tag, "_sum"}, res_sum[63:0] | res_sum[127:64] | res_sum[191:128], 0);
      check({tag, "_cnt"}, res_cnt, 0);
      check({tag, "_ovf"}, res_ovf, 0);
   endtask

   // One cycle of downstream behaviour: drive queued results, pick ready, score transfers.
   task automatic handle(input bit rnd, input bit auto_res);
      logic [31:0] r;
      for (int c = 0; c < NC; c++) begin
         if (pend_q[c].size() > 0) begin
            res_valid[c] = 1'b1;
            res_data[c*DW +: DW] = pend_q[c].pop_front();
         end else begin
            res_valid[c] = 1'b0;
         end
      end
      desc_ready = 3'b111;
      if (rnd) begin
         r = $urandom_range(0, 1);
         desc_ready[1] = r[0];
      end
      for (int c = 0; c < NC; c++) begin
         logic [95:0] pl;
         desc_t e;
         pl = {desc_si[c*DW +: DW], desc_ei[c*DW +: DW], desc_id[c*DW +: DW]};
         if (stalled[c]) check($sformatf("stable_ch%0d", c), pl, prev_pl[c]);
         if (desc_valid[c] && desc_ready[c]) begin
            if (exp_q[c].size() == 0) begin
               check($sformatf("extra_desc_ch%0d", c), pl, 0);
            end else begin
               e = exp_q[c].pop_front();
               check($sformatf("desc_ch%0d", c), pl, {e.si, e.ei, e.id});
               if (auto_res) pend_q[c].push_back((c == 2) ? e.id + 1 : 1);
            end
         end
         stalled[c] = desc_valid[c] && !desc_ready[c];
         prev_pl[c] = pl;
      end
   endtask

   task automatic run_cfg(input cfg_t t);
      int unsigned n [NC];
      int cyc, first;
      bit seen_done;
      n[0] = t.n0; n[1] = t.n1; n[2] = t.n2;
      clear_model();
      do_start(t.ns, t.n0, t.n1, t.n2);
      check("check_busy", busy, 1);
      check("err_clr", err, 0);
      check("check_valid", desc_valid, 0);
      if (t.exp_err) begin
         cycle();
         check("err_done", done, 1);
         check("err_flag", err, 1);
         check("err_valid", desc_valid, 0);
         cycle();
         check("err_done_pulse", done, 0);
         check("err_busy_fall", busy, 0);
         check("err_sticky", err, 1);
         return;
      end
      push_expected(t.ns, t.n0, t.n1, t.n2);
      cyc = 0; first = -1; seen_done = 0;
      while (cyc < 20000 && !seen_done) begin
         cycle();
         cyc++;
         handle(t.rnd, 1'b1);
         if (t.glitch && cyc == 10) begin start = 1'b1; n_samples = 5; end
         if (t.glitch && cyc == 11) begin start = 1'b0; n_samples = t.ns; end
         if (first < 0 && desc_valid != 0) first = cyc;
         if (done) begin
            seen_done = 1;
            check("busy_in_done", busy, 1);
         end
      end
      check("done_seen", seen_done, 1);
      check("first_valid_lat", first, FIRST_LAT);
      for (int c = 0; c < NC; c++) begin
         check($sformatf("size_ch%0d", c), chunk_size[c*DW +: DW], t.ns / n[c]);
         check($sformatf("cnt_ch%0d", c), res_cnt[c*DW +: DW], n[c]);
         check($sformatf("left_ch%0d", c), exp_q[c].size(), 0);
      end
      check("sum_ch0", res_sum[0 +: AW], t.n0);
      check("sum_ch1", res_sum[AW +: AW], t.n1);
      check("sum_ch2", res_sum[2*AW +: AW], (64'(t.n2) * (t.n2 + 1)) / 2);
      check("ovf_clear", res_ovf, 0);
      check("err_clear", err, 0);
      res_valid = '0;
      cycle();
      check("done_pulse", done, 0);
      check("busy_fall", busy, 0);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; start = 1'b0; n_samples = '0; n_chunks = '0;
      desc_ready = '0; res_valid = '0; res_data = '0;
      tbl[0] = '{ns:301,  n0:10,  n1:20, n2:30,   exp_err:0, rnd:0, glitch:1};
      tbl[1] = '{ns:301,  n0:10,  n1:20, n2:30,   exp_err:0, rnd:1, glitch:0};
      tbl[2] = '{ns:301,  n0:10,  n1:0,  n2:30,   exp_err:1, rnd:0, glitch:0};
      tbl[3] = '{ns:301,  n0:302, n1:20, n2:30,   exp_err:1, rnd:0, glitch:0};
      tbl[4] = '{ns:301,  n0:301, n1:1,  n2:7,    exp_err:0, rnd:0, glitch:0};
      tbl[5] = '{ns:1000, n0:3,   n1:7,  n2:1000, exp_err:0, rnd:1, glitch:0};
      #12;
      check_all_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 6; i++) run_cfg(tbl[i]);

      // Overflow: hold the final ch0 result back so a 31st ch2 word lands in DISPATCH.
      clear_model();
      do_start(301, 10, 20, 30);
      push_expected(301, 10, 20, 30);
      guard = 0;
      do begin
         cycle(); handle(1'b0, 1'b0); guard++;
      end while (guard < 400 && !(guard > FIRST_LAT && desc_valid == 0));
      check("ovf_all_issued", desc_valid, 0);
      for (int k = 0; k < 30; k++) pend_q[2].push_back(k + 1);
      for (int k = 0; k < 20; k++) pend_q[1].push_back(1);
      for (int k = 0; k < 9; k++)  pend_q[0].push_back(1);
      guard = 0;
      while (guard < 60 && (pend_q[0].size() + pend_q[1].size() + pend_q[2].size()) != 0) begin
         cycle(); handle(1'b0, 1'b0); guard++;
      end
      pend_q[2].push_back(99);
      cycle(); handle(1'b0, 1'b0);
      cycle(); handle(1'b0, 1'b0);
      check("ovf_flag", res_ovf, 1);
      check("ovf_sum2", res_sum[2*AW +: AW], 465);
      check("ovf_cnt2", res_cnt[2*DW +: DW], 30);
      check("ovf_still_busy", busy, 1);
      pend_q[0].push_back(1);
      guard = 0;
      while (guard < 20 && !done) begin
         cycle(); handle(1'b0, 1'b0); guard++;
      end
      check("ovf_done", done, 1);
      check("ovf_sums", {res_sum[2*AW +: 32], res_sum[AW +: 32], res_sum[0 +: 32]}, {32'd465, 32'd20, 32'd10});
      check("ovf_cnts", res_cnt, {32'd30, 32'd20, 32'd10});
      check("ovf_sticky", res_ovf, 1);
      res_valid = '0;
      cycle();
      check("ovf_busy_fall", busy, 0);

      // Asynchronous reset in the middle of dispatch, then a clean rerun.
      clear_model();
      do_start(301, 10, 20, 30);
      for (int k = 0; k < FIRST_LAT + 3; k++) cycle();
      check("mid_valid_up", desc_valid != 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      desc_ready = '0; res_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      check("rst_idle_valid", desc_valid, 0);
      run_cfg(tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout actual=1 required=0");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
